// File: rtl/prog_sequencer.sv
// Multi-cycle control sequencer for the 9-bit-instruction processor: steps each
// instruction through FETCH/DECODE/EXEC/[MEM]/WB and drives the datapath strobes.
module prog_sequencer #(
    parameter int          IW          = 9,
    parameter int          OPW         = 3,
    parameter int          MEM_TIMEOUT = 15,
    parameter logic [15:0] CNT_START   = 16'h0000
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    output logic           o_done,
    output logic           o_err,
    input  logic [IW-1:0]  i_instr,
    input  logic           i_prog_end,
    input  logic           i_branch_taken,
    input  logic           i_mem_ready,
    output logic           o_ir_load,
    output logic           o_pc_inc,
    output logic           o_pc_branch,
    output logic [1:0]     o_branch_sel,
    output logic [OPW-1:0] o_alu_op,
    output logic           o_rf_we,
    output logic           o_wb_sel_mem,
    output logic           o_mem_re,
    output logic           o_mem_we,
    output logic [15:0]    o_instr_count
);
    localparam int         TW        = $clog2(MEM_TIMEOUT + 1);
    localparam logic [2:0] OP_LOAD   = 3'b101;
    localparam logic [2:0] OP_STORE  = 3'b110;
    localparam logic [2:0] OP_BRANCH = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE, S_ERR
    } state_t;

    state_t        r_state, w_next;
    logic [2:0]    r_op;
    logic [1:0]    r_bsel;
    logic [TW-1:0] r_tmo;
    logic [15:0]   r_cnt;
    logic          w_retire, w_latch, w_clr_cnt, w_tmo_last;

    // r_tmo holds the number of MEM cycles already completed without ready
    assign w_tmo_last = (r_tmo == TW'(MEM_TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_bsel  <= '0;
            r_tmo   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_op   <= i_instr[IW-1:IW-3];
                r_bsel <= i_instr[4:3];
            end
            if (r_state != S_MEM)
                r_tmo <= '0;
            else if (!i_mem_ready && !w_tmo_last)
                r_tmo <= r_tmo + 1'b1;
            if (w_clr_cnt)
                r_cnt <= CNT_START;
            else if (w_retire && r_cnt != 16'hFFFF)
                r_cnt <= r_cnt + 16'd1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        w_latch      = 1'b0;
        w_clr_cnt    = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        o_ir_load    = 1'b0;
        o_pc_inc     = 1'b0;
        o_pc_branch  = 1'b0;
        o_alu_op     = '0;
        o_rf_we      = 1'b0;
        o_wb_sel_mem = 1'b0;
        o_mem_re     = 1'b0;
        o_mem_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next    = S_FETCH;
                    w_clr_cnt = 1'b1;
                end
            end
            S_FETCH: begin
                if (i_prog_end) begin
                    w_next = S_DONE;
                end else begin
                    o_ir_load = 1'b1;
                    w_latch   = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                case (r_op)
                    OP_BRANCH: begin
                        o_pc_branch = i_branch_taken;
                        o_pc_inc    = !i_branch_taken;
                        w_retire    = 1'b1;
                        w_next      = S_FETCH;
                    end
                    OP_LOAD, OP_STORE: w_next = S_MEM;
                    default: begin
                        o_alu_op = OPW'(r_op);
                        w_next   = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                o_mem_re = (r_op == OP_LOAD);
                o_mem_we = (r_op == OP_STORE);
                if (i_mem_ready) begin
                    if (r_op == OP_LOAD) begin
                        w_next = S_WB;
                    end else begin
                        o_pc_inc = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                end else if (w_tmo_last) begin
                    w_next = S_ERR;
                end
            end
            S_WB: begin
                o_rf_we      = 1'b1;
                o_wb_sel_mem = (r_op == OP_LOAD);
                o_pc_inc     = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_DONE: begin
                o_done = 1'b1;
                if (!i_start) w_next = S_IDLE;
            end
            S_ERR:   o_err = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

    assign o_branch_sel  = r_bsel;
    assign o_instr_count = r_cnt;

endmodule
